// File: rtl/input_debouncer.sv
// input_debouncer: per-channel 2-flop synchronizer followed by a counter-based
// debouncer. A synchronized level must differ from the accepted (stable) level
// for DEBOUNCE_CYCLES consecutive cycles before it is accepted. Acceptance
// produces a one-cycle rise or fall pulse aligned with the pins_out change.
//
// Optional feature macro: DEBOUNCE_EVENT_LATCH_EN
//   defined   -> sticky per-channel event_status flags (set on rise/fall,
//                cleared by event_clear, set wins) and a registered irq.
//   undefined -> event_status and irq tie to 0 and event_clear is ignored.
module input_debouncer #(
  parameter int   WIDTH           = 2,
  parameter int   CNT_W           = 20,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic             CLK,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] event_clear,
  output logic [WIDTH-1:0] event_status,
  output logic             irq
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

  // Terminal count: the mismatch seen with this count value is the one accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage synchronizer for the asynchronous pad inputs.
  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      meta_q <= {WIDTH{RESET_LEVEL}};
      sync_q <= {WIDTH{RESET_LEVEL}};
    end else begin
      meta_q <= pins_in;
      sync_q <= meta_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    deb_state_t       state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // The channel is pending whenever the synchronized input disagrees with the accepted level.
    always_comb begin
      state = (sync_q[i] != stable_q) ? PENDING : IDLE;
    end

    // Next-state logic: count while pending, accept at terminal count, drop the count on a bounce.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      case (state)
        IDLE: begin
          cnt_d = '0;
        end
        PENDING: begin
          if (cnt_q == CNT_MAX) begin
            stable_d = sync_q[i];
            rise_d   = sync_q[i];
            fall_d   = ~sync_q[i];
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    // Channel state registers; pulses are registered so they line up with the pins_out change.
    always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
        cnt_q    <= '0;
        stable_q <= RESET_LEVEL;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    assign pins_out[i] = stable_q;
    assign rise[i]     = rise_q;
    assign fall[i]     = fall_q;
  end

`ifdef DEBOUNCE_EVENT_LATCH_EN
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic             irq_q;

  // Sticky flags: a visible pulse sets the flag and overrides a clear in the same cycle.
  always_comb begin
    status_d = (status_q & ~event_clear) | rise | fall;
  end

  // irq is registered alongside the flags so both change on the same edge.
  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |status_d;
    end
  end

  assign event_status = status_q;
  assign irq          = irq_q;
`else
  logic [WIDTH-1:0] unused_event_clear;

  assign unused_event_clear = event_clear;
  assign event_status       = '0;
  assign irq                = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer (WIDTH=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0)
// plus a single-channel instance with DEBOUNCE_CYCLES=1.
// Expected event_status/irq follow DEBOUNCE_EVENT_LATCH_EN.
module tb_input_debouncer;

  localparam int WIDTH = 2;
  localparam int CNT_W = 4;
  localparam int DEB   = 4;

  logic             CLK = 1'b0;
  logic             reset_in;
  logic [WIDTH-1:0] pins_in;
  logic [WIDTH-1:0] event_clear;
  logic [WIDTH-1:0] pins_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] event_status;
  logic             irq;

  logic [0:0] p1_in;
  logic [0:0] p1_clear;
  logic [0:0] p1_out;
  logic [0:0] p1_rise;
  logic [0:0] p1_fall;
  logic [0:0] p1_status;
  logic       p1_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] pins;
    logic [1:0] clr;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] status;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];

  input_debouncer #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEB), .RESET_LEVEL(1'b0)
  ) dut (
    .CLK(CLK), .reset_in(reset_in), .pins_in(pins_in), .pins_out(pins_out),
    .rise(rise), .fall(fall), .event_clear(event_clear),
    .event_status(event_status), .irq(irq)
  );

  input_debouncer #(
    .WIDTH(1), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)
  ) dut1 (
    .CLK(CLK), .reset_in(reset_in), .pins_in(p1_in), .pins_out(p1_out),
    .rise(p1_rise), .fall(p1_fall), .event_clear(p1_clear),
    .event_status(p1_status), .irq(p1_irq)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [1:0] st(input logic [1:0] s);
`ifdef DEBOUNCE_EVENT_LATCH_EN
    return s;
`else
    return 2'b00;
`endif
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input string tag, input logic [1:0] pins, input logic [1:0] clr,
                     input logic [1:0] out, input logic [1:0] r, input logic [1:0] f,
                     input logic [1:0] s);
    vec_t v;
    v.pins = pins; v.clr = clr; v.out = out; v.rise = r; v.fall = f; v.status = s; v.tag = tag;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    pins_in     = v.pins;
    event_clear = v.clr;
    expq.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t v;
    @(posedge CLK);
    #1;
    if (expq.size() == 0) begin
      compare("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      v = expq.pop_front();
      compare({v.tag, ".pins_out"}, 32'(pins_out), 32'(v.out));
      compare({v.tag, ".rise"}, 32'(rise), 32'(v.rise));
      compare({v.tag, ".fall"}, 32'(fall), 32'(v.fall));
      compare({v.tag, ".event_status"}, 32'(event_status), 32'(v.status));
      compare({v.tag, ".irq"}, 32'(irq), 32'(|v.status));
    end
  endtask

  task automatic run_table();
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      checkOutput();
    end
    vecs.delete();
  endtask

  task automatic check_all_zero(input string tag);
    compare({tag, ".pins_out"}, 32'(pins_out), 32'd0);
    compare({tag, ".rise"}, 32'(rise), 32'd0);
    compare({tag, ".fall"}, 32'(fall), 32'd0);
    compare({tag, ".event_status"}, 32'(event_status), 32'd0);
    compare({tag, ".irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    int lat;
    reset_in    = 1'b1;
    pins_in     = '0;
    event_clear = '0;
    p1_in       = '0;
    p1_clear    = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    reset_in = 1'b0;

    // Release with pins at reset level: nothing happens.
    add(3, "idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Channel 0 rises, accepted 6 edges after first sampling.
    add(5, "rise0_wait", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "rise0_edge", 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
    add(3, "rise0_after", 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, st(2'b01));
    // Channel 1 bounce: high for only 3 cycles is not accepted.
    add(3, "bounce1_hi", 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, st(2'b01));
    add(6, "bounce1_lo", 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, st(2'b01));
    // Channel 0 falls; clear during the fall pulse loses, clear next cycle wins.
    add(5, "fall0_wait", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, st(2'b01));
    add(1, "fall0_edge", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, st(2'b01));
    add(1, "clr_vs_set", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, st(2'b01));
    add(1, "clr_wins", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "clr_done", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Channel 1 rises so reset has something to clear.
    add(5, "rise1_wait", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "rise1_edge", 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00);
    add(2, "rise1_after", 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, st(2'b10));
    // Channel 0 goes pending for two counting cycles before reset hits.
    add(4, "pend0", 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, st(2'b10));
    run_table();

    // Mid-pending reset: outputs clear immediately and stay clear with no pulse.
    #3;
    reset_in = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge CLK);
    #1;
    check_all_zero("reset_hold");
    reset_in = 1'b0;

    // Both pins held high from release: full latency, simultaneous rise.
    add(5, "both_wait", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, "both_edge", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(2, "both_after", 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, st(2'b11));
    run_table();

    // DEBOUNCE_CYCLES=1 instance: accepted on the third edge.
    compare("d1.pins_out_init", 32'(p1_out), 32'd0);
    @(negedge CLK);
    p1_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #1;
      if (p1_out === 1'b1) begin
        lat = k;
        break;
      end
    end
    compare("d1.latency", 32'(lat), 32'd3);
    compare("d1.rise", 32'(p1_rise), 32'd1);
    @(posedge CLK);
    #1;
    compare("d1.rise_width", 32'(p1_rise), 32'd0);
    compare("d1.pins_out_hold", 32'(p1_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter WIDTH, default 2: number of independent input channels (buttons BUT1/BUT2 feeding pin-interrupt and GPIO read).
REQ-002 Parameter CNT_W, default 20: debounce counter width.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000: cycles a synchronized input must stay changed before acceptance; legal range 1 to 2^CNT_W-1.
REQ-004 Parameter RESET_LEVEL, default 1'b0: level loaded into all synchronizer and stable registers at reset.
REQ-005 CLK  input  1  clock, all logic on rising edge.
REQ-006 reset_in  input  1  reset, asynchronous, active-high.
REQ-007 pins_in  input  WIDTH  raw asynchronous pad inputs.
REQ-008 pins_out  output  WIDTH  debounced levels.
REQ-009 rise  output  WIDTH  one-cycle pulse on accepted 0->1 transition.
REQ-010 fall  output  WIDTH  one-cycle pulse on accepted 1->0 transition.
REQ-011 event_clear  input  WIDTH  per-channel sticky-status clear, sampled each cycle.
REQ-012 event_status  output  WIDTH  per-channel sticky edge flag.
REQ-013 irq  output  1  OR of event_status.

Function
REQ-014 Each channel SHALL pass pins_in through a 2-flop synchronizer; the second-stage value is "sync".
REQ-015 Each channel SHALL hold a stable register (driving pins_out) and a CNT_W-bit counter; states: IDLE (sync == stable, counter 0) and PENDING (sync != stable).
REQ-016 IDLE -> PENDING when sync != stable; counter increments by 1 each cycle while PENDING.
REQ-017 PENDING with sync == stable (bounce) SHALL return to IDLE and zero the counter in that cycle, with no output change.
REQ-018 When sync != stable and counter == DEBOUNCE_CYCLES-1, stable SHALL load sync, counter SHALL zero, and the matching rise/fall SHALL pulse high for exactly the cycle in which pins_out changes.
REQ-019 Latency: a clean pins_in step held constant SHALL appear on pins_out DEBOUNCE_CYCLES+2 rising edges after first sampling.
REQ-020 DEBOUNCE_CYCLES=1 SHALL accept a change on the first mismatch cycle (latency 3).
REQ-021 Counter SHALL never wrap; it is bounded by DEBOUNCE_CYCLES-1.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-023 rise and fall of one channel SHALL never be high together.

Reset
REQ-024 While reset_in is high: synchronizer flops and pins_out = {WIDTH{RESET_LEVEL}}, counters 0, rise/fall 0, event_status 0, irq 0.
REQ-025 Reset release SHALL NOT generate rise/fall when pins_in equals RESET_LEVEL; a differing pin SHALL be debounced normally (full DEBOUNCE_CYCLES+2 latency).
REQ-026 Reset asserted mid-PENDING SHALL discard the pending count; no pulse is emitted.

Configuration
REQ-027 Macro DEBOUNCE_EVENT_LATCH_EN: when defined, event_status[i] SHALL set on rise[i] or fall[i], clear on event_clear[i], set winning when both occur in one cycle; irq = |event_status, registered with event_status.
REQ-028 When DEBOUNCE_EVENT_LATCH_EN is undefined, event_status and irq SHALL be constant 0, event_clear ignored, and no latch flops synthesized; all other behaviour unchanged.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, macro defined unless stated)
REQ-029 pins_in[0] 0->1 held -> pins_out[0]=1 and rise[0]=1 exactly 6 edges later, rise[0] one cycle wide, event_status=2'b01, irq=1.
REQ-030 pins_in[1] high for 3 cycles then low (bounce) -> pins_out[1] stays 0, no rise/fall, event_status unchanged.
REQ-031 pins_out[0]=1, pins_in[0] -> 0 held -> fall[0] after 6 edges; event_clear[0] pulsed in same cycle as fall[0] -> event_status[0] stays 1; clear pulsed next cycle -> event_status[0]=0, irq=0.
REQ-032 pins_in=2'b11 held from reset release -> both pins_out rise in same cycle, 6 edges after release; rise=2'b11 for one cycle.
REQ-033 reset_in asserted 2 cycles into a PENDING run -> all outputs 0 immediately; after release, full 6-edge latency observed again.
REQ-034 Macro undefined, repeat REQ-029 -> pins_out/rise identical, event_status=0, irq=0 throughout.
